pcie_phy_tx_scrambler: RTL and testbench

Transmit-side byte stage that sits directly upstream of the 8b/10b encoder. It accepts characters from the link layer or ordered-set source through a valid/ready handshake and applies the Gen1 scrambler. It inserts SKP ordered sets at a fixed interval and fills idle cycles with logical idle (scrambled D0.0). Every cycle it drives one registered character, {ctrl_out, data_out}, into the encoder address input.

---
 rtl/pcie_phy_tx_scrambler_if.sv | 22 ++
 rtl/pcie_phy_tx_scrambler.sv | 141 ++++++++++++++
 tb/tb_pcie_phy_tx_scrambler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_phy_tx_scrambler_if.sv
// Character bus between the link-layer source, the TX scrambler stage and the
// 8b/10b encoder input. The master side is the source (and encoder observer).
interface pcie_phy_tx_scrambler_if;
  logic [7:0] in_data;
  logic       in_k;
  logic       in_noscr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_out;
  logic       ctrl_out;
  logic       skp_active;

  modport master (
    output in_data, in_k, in_noscr, in_valid,
    input  in_ready, data_out, ctrl_out, skp_active
  );

  modport slave (
    input  in_data, in_k, in_noscr, in_valid,
    output in_ready, data_out, ctrl_out, skp_active
  );
endinterface

// File: rtl/pcie_phy_tx_scrambler.sv
// Gen1 TX byte stage ahead of the 8b/10b encoder: SKP insertion, logical idle fill,
// and (with PCIE_PHY_SCRAMBLE_EN defined) the x^16+x^5+x^4+x^3+1 data scrambler.
module pcie_phy_tx_scrambler #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter logic [7:0]  COM_CHAR     = 8'hBC,
  parameter logic [7:0]  SKP_CHAR     = 8'h1C
) (
  input  logic                   clk,
  input  logic                   rst,
  pcie_phy_tx_scrambler_if.slave bus
);
  localparam logic [15:0] CNT_LAST = 16'(SKP_INTERVAL - 1);
  localparam logic [7:0]  K_STP = 8'hFB;
  localparam logic [7:0]  K_SDP = 8'h5C;
  localparam logic [7:0]  K_END = 8'hFD;
  localparam logic [7:0]  K_EDB = 8'hFE;

  // State names the ordered-set character currently on data_out; SKP3 is the
  // cycle the last SKP is visible while the next normal character is chosen.
  typedef enum logic [2:0] {IDLE, COM, SKP1, SKP2, SKP3} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        in_pkt_q, in_pkt_d;
  logic [7:0]  data_q, data_d;
  logic        ctrl_q, ctrl_d;
  logic        skp_q, skp_d;

  logic        start, insert, accept;
  logic [7:0]  chr;
  logic        chr_k;

`ifdef PCIE_PHY_SCRAMBLE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [23:0] scr;

  // Returns {next_lfsr, scrambled_byte}; bits go LSB first.
  function automatic logic [23:0] scramble8(input logic [15:0] seed, input logic [7:0] din);
    logic [15:0] l;
    logic [7:0]  o;
    l = seed;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o[i] = din[i] ^ l[15];
      l    = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
    end
    return {l, o};
  endfunction
`else
  logic unused_noscr;
  assign unused_noscr = bus.in_noscr;
`endif

  always_comb begin
    start  = (state_q == IDLE) && pending_q && !in_pkt_q;
    insert = start || (state_q == COM) || (state_q == SKP1) || (state_q == SKP2);
    accept = bus.in_valid && !insert;

    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COM;
      COM:     state_d = SKP1;
      SKP1:    state_d = SKP2;
      SKP2:    state_d = SKP3;
      SKP3:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    chr   = 8'h00;
    chr_k = 1'b0;
    if (insert) begin
      chr   = start ? COM_CHAR : SKP_CHAR;
      chr_k = 1'b1;
    end else if (accept) begin
      chr   = bus.in_data;
      chr_k = bus.in_k;
    end

    in_pkt_d = in_pkt_q;
    if (accept && bus.in_k) begin
      if (bus.in_data == K_STP || bus.in_data == K_SDP) in_pkt_d = 1'b1;
      else if (bus.in_data == K_END || bus.in_data == K_EDB) in_pkt_d = 1'b0;
    end

    // Counter parks at zero through the ordered set and saturates at the last value.
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (start) begin
      cnt_d     = '0;
      pending_d = 1'b0;
    end else if (!insert) begin
      if (cnt_q == CNT_LAST) pending_d = 1'b1;
      else                   cnt_d     = cnt_q + 16'd1;
    end

    ctrl_d = chr_k;
    skp_d  = insert;
`ifdef PCIE_PHY_SCRAMBLE_EN
    scr    = scramble8(lfsr_q, chr);
    data_d = (!chr_k && !(accept && bus.in_noscr)) ? scr[7:0] : chr;
    if (chr_k && chr == COM_CHAR)      lfsr_d = 16'hFFFF;
    else if (chr_k && chr == SKP_CHAR) lfsr_d = lfsr_q;
    else                               lfsr_d = scr[23:8];
`else
    data_d = chr;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      in_pkt_q  <= 1'b0;
      data_q    <= 8'h00;
      ctrl_q    <= 1'b0;
      skp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      in_pkt_q  <= in_pkt_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      skp_q     <= skp_d;
    end
  end

`ifdef PCIE_PHY_SCRAMBLE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hFFFF;
    else     lfsr_q <= lfsr_d;
  end
`endif

  assign bus.in_ready   = !insert;
  assign bus.data_out   = data_q;
  assign bus.ctrl_out   = ctrl_q;
  assign bus.skp_active = skp_q;
endmodule

// File: tb/tb_pcie_phy_tx_scrambler.sv
// Bench for pcie_phy_tx_scrambler: symbol-stream model plus directed literal checks.
// Scrambler expectations follow PCIE_PHY_SCRAMBLE_EN as the RTL does.
module tb_pcie_phy_tx_scrambler;
  localparam int         SKP_INT = 16;
  localparam logic [7:0] COM     = 8'hBC;
  localparam logic [7:0] SKP     = 8'h1C;
  localparam logic [7:0] REF [7] = '{8'hBC, 8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;
  int   cyc  = 0;
  bit   chk_en = 1'b0;

  pcie_phy_tx_scrambler_if bus();

  pcie_phy_tx_scrambler #(
    .SKP_INTERVAL(SKP_INT),
    .COM_CHAR    (COM),
    .SKP_CHAR    (SKP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: stream of emitted symbols; a burst is queued once SKP_INT normal
  // symbols have gone out since the last burst and no packet is open.
  logic [15:0] m_lfsr   = 16'hFFFF;
  int          m_normal = 0;
  bit          m_pkt    = 1'b0;
  logic [7:0]  m_bq[$];
  logic [7:0]  e_data = 8'h00;
  logic        e_ctrl = 1'b0;
  logic        e_skp  = 1'b0;

  function automatic bit model_ready();
    return (m_bq.size() == 0) && !((m_normal >= SKP_INT) && !m_pkt);
  endfunction

`ifdef PCIE_PHY_SCRAMBLE_EN
  function automatic logic [7:0] keystream(input logic [15:0] s, output logic [15:0] s_next);
    logic [7:0] ks;
    ks = '0;
    for (int b = 0; b < 8; b++) begin
      ks[b] = s[15];
      s = (s << 1) ^ (s[15] ? 16'h0039 : 16'h0000);
    end
    s_next = s;
    return ks;
  endfunction
`endif

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_lfsr = 16'hFFFF; m_normal = 0; m_pkt = 1'b0; m_bq.delete();
      e_data = 8'h00; e_ctrl = 1'b0; e_skp = 1'b0; cyc = 0;
    end else begin : step
      logic [7:0] c;
      logic k, scr, ins;
`ifdef PCIE_PHY_SCRAMBLE_EN
      logic [7:0]  ks;
      logic [15:0] nxt;
`endif
      cyc++;
      if (m_bq.size() == 0 && m_normal >= SKP_INT && !m_pkt) begin
        m_bq = '{COM, SKP, SKP, SKP};
        m_normal = 0;
      end
      ins = 1'b0;
      scr = 1'b0;
      if (m_bq.size() != 0) begin
        c = m_bq.pop_front(); k = 1'b1; ins = 1'b1;
      end else if (bus.in_valid) begin
        c = bus.in_data; k = bus.in_k; scr = !k && !bus.in_noscr;
        if (k && (c == 8'hFB || c == 8'h5C)) m_pkt = 1'b1;
        if (k && (c == 8'hFD || c == 8'hFE)) m_pkt = 1'b0;
      end else begin
        c = 8'h00; k = 1'b0; scr = 1'b1;
      end
      if (!ins) m_normal++;
      e_ctrl = k;
      e_skp  = ins;
`ifdef PCIE_PHY_SCRAMBLE_EN
      ks     = keystream(m_lfsr, nxt);
      e_data = scr ? (c ^ ks) : c;
      if (k && c == COM)       m_lfsr = 16'hFFFF;
      else if (!(k && c == SKP)) m_lfsr = nxt;
`else
      e_data = c;
`endif
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && !rst) begin
      nvec++;
      if (bus.data_out !== e_data || bus.ctrl_out !== e_ctrl ||
          bus.skp_active !== e_skp || bus.in_ready !== model_ready()) begin
        nmis++;
        $display("FAIL model cyc=%0d got d=%h k=%b skp=%b rdy=%b want d=%h k=%b skp=%b rdy=%b",
                 cyc, bus.data_out, bus.ctrl_out, bus.skp_active, bus.in_ready,
                 e_data, e_ctrl, e_skp, model_ready());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0; bus.in_k = 1'b0; bus.in_noscr = 1'b0; bus.in_data = 8'h00;
  endtask

  // Presents one character until accepted; returns how many cycles it was offered.
  task automatic send(input logic [7:0] d, input logic k, input logic ns, output int tries);
    bit ok;
    ok = 1'b0;
    tries = 0;
    bus.in_data = d; bus.in_k = k; bus.in_noscr = ns; bus.in_valid = 1'b1;
    while (!ok && tries < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      tries++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      nvec++; nmis++;
      $display("FAIL send_timeout: got no acceptance of %h want acceptance", d);
    end
  endtask

  task automatic goto(input int n);
    if (cyc < n) begin
      repeat (n - cyc) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t, bubbles, low, e_end, b;
    logic [7:0] idle_ff, want;
`ifdef PCIE_PHY_SCRAMBLE_EN
    idle_ff = 8'hFF;
`else
    idle_ff = 8'h00;
`endif
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", bus.data_out, 8'h00);
    chk("reset_ctrl", bus.ctrl_out, 1'b0);
    chk("reset_skp",  bus.skp_active, 1'b0);
    chk("reset_rdy",  bus.in_ready, 1'b1);

    // COM then logical idle: reference scrambler sequence
    bus.in_valid = 1'b1; bus.in_k = 1'b1; bus.in_data = COM;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    idle_in();
    chk("ref_com_k", bus.ctrl_out, 1'b1);
    chk("ref_byte0", bus.data_out, REF[0]);
    for (int j = 1; j < 7; j++) begin
      @(posedge clk);
      #1;
`ifdef PCIE_PHY_SCRAMBLE_EN
      want = REF[j];
`else
      want = 8'h00;
`endif
      chk($sformatf("ref_byte%0d", j), bus.data_out, want);
    end

    // First SKP burst: outputs at cycles 17..20, in_ready low 4 cycles
    low = 0;
    for (int j = 15; j <= 21; j++) begin
      goto(j);
      low += bus.in_ready ? 0 : 1;
      if (j >= 17 && j <= 20) begin
        chk($sformatf("burst_data_c%0d", j), bus.data_out, (j == 17) ? COM : SKP);
        chk($sformatf("burst_k_c%0d", j), bus.ctrl_out, 1'b1);
        chk($sformatf("burst_skp_c%0d", j), bus.skp_active, 1'b1);
      end else begin
        chk($sformatf("noburst_skp_c%0d", j), bus.skp_active, 1'b0);
      end
    end
    chk("burst1_rdy_low_cycles", low, 4);
    chk("post_burst_idle", bus.data_out, idle_ff);

    // Unscrambled D byte after COM keeps the LFSR advancing
    send(COM, 1'b1, 1'b0, t);
    chk("noscr_com", bus.data_out, COM);
    send(8'h4A, 1'b0, 1'b1, t);
    chk("noscr_data", bus.data_out, 8'h4A);
    idle_in();
    @(posedge clk);
    #1;
`ifdef PCIE_PHY_SCRAMBLE_EN
    want = 8'h17;
`else
    want = 8'h00;
`endif
    chk("noscr_next_idle", bus.data_out, want);

    // Packet spanning the SKP deadline: no bubbles, burst right after END
    bubbles = 0;
    send(8'hFB, 1'b1, 1'b0, t);
    bubbles += t - 1;
    for (int i = 0; i < 30; i++) begin
      send(8'(i * 37 + 5), 1'b0, 1'b0, t);
      bubbles += t - 1;
    end
    send(8'hFD, 1'b1, 1'b0, t);
    bubbles += t - 1;
    idle_in();
    e_end = cyc;
    chk("pkt_no_bubble", bubbles, 0);
    chk("pkt_end_out", bus.data_out, 8'hFD);
    low = 0;
    for (int j = 0; j < 6; j++) begin
      goto(e_end + j);
      low += bus.in_ready ? 0 : 1;
      if (j == 1) begin
        chk("pkt_burst_com", bus.data_out, COM);
        chk("pkt_burst_skp", bus.skp_active, 1'b1);
      end
    end
    chk("pkt_rdy_low_cycles", low, 4);

    // Async reset while the second SKP of the next burst is on the outputs
    b = e_end + 21;
    goto(b + 2);
    chk("pre_rst_skp2_data", bus.data_out, SKP);
    chk("pre_rst_skp2_act", bus.skp_active, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data", bus.data_out, 8'h00);
    chk("async_rst_ctrl", bus.ctrl_out, 1'b0);
    chk("async_rst_skp",  bus.skp_active, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    goto(1);
    chk("rst_first_idle", bus.data_out, idle_ff);
    goto(16);
    chk("rst_cnt_c16_skp", bus.skp_active, 1'b0);
    goto(17);
    chk("rst_cnt_c17_skp", bus.skp_active, 1'b1);
    chk("rst_cnt_c17_com", bus.data_out, COM);
    goto(21);
    chk("rst_post_burst_idle", bus.data_out, idle_ff);
    goto(24);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
